// File: rtl/imm_encoder.sv
// Narrows 16-bit signed constants into 12-bit immediate chunks:
// one SHORT chunk when the value fits, otherwise a HI/LO pair.
module imm_encoder #(
  parameter int IN_W  = 16,
  parameter int IMM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IMM_W-1:0] out_imm,
  output logic [1:0]       out_kind,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      long_count
);

  localparam int LO_W  = IN_W - IMM_W;
  localparam int PAD_W = IMM_W - LO_W;

  localparam logic [1:0] KIND_SHORT = 2'b00;
  localparam logic [1:0] KIND_HI    = 2'b01;
  localparam logic [1:0] KIND_LO    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHORT,
    S_HI,
    S_LO
  } state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] hold_q, hold_d;
  logic [15:0]     cnt_q, cnt_d;

  // Value fits the immediate when every bit above the sign bit copies it.
  logic [IN_W-IMM_W:0] top_bits;
  logic                fits;

  assign top_bits = in_data[IN_W-1:IMM_W-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_kind  = KIND_SHORT;
    out_imm   = '0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d = in_data;
          if (fits) begin
            state_d = S_SHORT;
          end else begin
            state_d = S_HI;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_SHORT: begin
        out_valid = 1'b1;
        out_kind  = KIND_SHORT;
        out_imm   = hold_q[IMM_W-1:0];
        if (out_ready) state_d = S_IDLE;
      end
      S_HI: begin
        out_valid = 1'b1;
        out_kind  = KIND_HI;
        out_imm   = hold_q[IN_W-1:LO_W];
        if (out_ready) state_d = S_LO;
      end
      S_LO: begin
        out_valid = 1'b1;
        out_kind  = KIND_LO;
        out_imm   = {{PAD_W{1'b0}}, hold_q[LO_W-1:0]};
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign long_count = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised and directed bench for imm_encoder with an
// arithmetic reference model and chunk reconstruction.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_imm;
  logic [1:0]  out_kind;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] long_count;

  int errors   = 0;
  int checks   = 0;
  int exp_long = 0;
  int n_short  = 0;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_imm    (out_imm),
    .out_kind   (out_kind),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .long_count (long_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sx12(input logic [11:0] x);
    int r;
    r = int'(x);
    if (x[11]) r = r - 4096;
    return r;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_long_count"}, 32'(long_count),
        32'(exp_long > 65535 ? 65535 : exp_long));
  endtask

  // Send one constant at full throughput and check its chunks.
  task automatic run_one(input logic [15:0] v);
    int sv;
    int hi_exp;
    int lo_exp;
    int rec;
    logic [11:0] hi_got;
    bit fit;
    sv  = int'($signed(v));
    fit = (sv >= -2048) && (sv <= 2047);
    lo_exp = sv & 15;
    hi_exp = ((sv - lo_exp) / 16) & 12'hFFF;
    in_data   = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    @(negedge clk);
    chk("c0_valid", 32'(out_valid), 32'd1);
    if (fit) begin
      n_short++;
      chk("short_kind", 32'(out_kind), 32'd0);
      chk("short_imm", 32'(out_imm), 32'(sv & 12'hFFF));
      rec = sx12(out_imm);
      chk("short_recon", 32'(rec), 32'(sv));
    end else begin
      exp_long++;
      chk("hi_kind", 32'(out_kind), 32'd1);
      chk("hi_imm", 32'(out_imm), 32'(hi_exp));
      hi_got = out_imm;
      @(posedge clk); #1;
      @(negedge clk);
      chk("lo_valid", 32'(out_valid), 32'd1);
      chk("lo_kind", 32'(out_kind), 32'd2);
      chk("lo_imm", 32'(out_imm), 32'(lo_exp));
      rec = sx12(hi_got) * 16 + int'(out_imm[3:0]);
      chk("long_recon", 32'(rec), 32'(sv));
    end
    @(posedge clk); #1;
    @(negedge clk);
    idle_chk("post");
  endtask

  initial begin
    logic [15:0] v;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_imm", 32'(out_imm), 32'd0);
    chk("rst_out_kind", 32'(out_kind), 32'd0);
    chk("rst_long", 32'(long_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    run_one(16'h07FF);
    run_one(16'hF800);
    run_one(16'h1234);
    run_one(16'h0800);
    run_one(16'hF7FF);
    run_one(16'h8000);
    run_one(16'h7FFF);
    run_one(16'h0000);
    run_one(16'hFFFF);

    // Backpressure in HI with a new value already waiting upstream.
    in_data   = 16'h5A5A;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    exp_long++;
    in_data = 16'h0123;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_kind", 32'(out_kind), 32'd1);
      chk("bp_imm", 32'(out_imm), 32'h5A5);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hi_kind", 32'(out_kind), 32'd1);
    chk("bp_hi_imm", 32'(out_imm), 32'h5A5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_lo_kind", 32'(out_kind), 32'd2);
    chk("bp_lo_imm", 32'(out_imm), 32'h00A);
    chk("bp_lo_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    idle_chk("bp_idle");
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_short++;
    @(negedge clk);
    chk("bp_new_kind", 32'(out_kind), 32'd0);
    chk("bp_new_imm", 32'(out_imm), 32'h123);
    @(posedge clk); #1;
    @(negedge clk);
    idle_chk("bp_done");

    // Reset pulse while HI is pending.
    in_data  = 16'h4321;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rp_hi_kind", 32'(out_kind), 32'd1);
    rst = 1'b1;
    #1;
    exp_long = 0;
    chk("rp_out_valid", 32'(out_valid), 32'd0);
    chk("rp_in_ready", 32'(in_ready), 32'd1);
    chk("rp_long", 32'(long_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    idle_chk("rp_no_lo");
    @(posedge clk); #1;
    @(negedge clk);
    idle_chk("rp_still_idle");

    // Dense sweeps around each fit boundary and the 16-bit wrap.
    for (int i = 0; i < 48; i++) run_one(16'h07E8 + 16'(i));
    for (int i = 0; i < 48; i++) run_one(16'hF7E8 + 16'(i));
    for (int i = 0; i < 48; i++) run_one(16'h7FE8 + 16'(i));

    // Random constants, half drawn from the short range.
    for (int i = 0; i < 6000; i++) begin
      v = 16'($urandom);
      if (i % 2 == 0) v = {{4{v[11]}}, v[11:0]};
      run_one(v);
    end

    chk("final_long", 32'(long_count), 32'(exp_long));
    chk("short_seen", 32'(n_short > 3000), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Narrowing encoder for the stack processor's 12-bit immediate field; it runs in the opposite direction to `signextender`. It accepts 16-bit signed constants over a valid/ready handshake and emits a stream of 12-bit immediate chunks. Values that fit in 12 bits signed go out as one SHORT chunk. Any other value goes out as a HI/LO pair that the decode path reassembles with `signextender`, a 4-bit shift and an OR. It sits between the constant source (loader / literal FIFO) and the instruction word builder.

## Interface
- `IN_W`, 16, input constant width
- `IMM_W`, 12, immediate field width; LO chunk carries `IN_W-IMM_W` (=4) payload bits
- `clk` input 1 system clock; all state changes on the rising edge
- `rst` input 1 reset, asynchronous, active-high
- `in_data` input IN_W signed constant to encode
- `in_valid` input 1 `in_data` valid
- `in_ready` output 1 block can accept a constant
- `out_imm` output IMM_W immediate chunk
- `out_kind` output 2 chunk type: 2'b00 SHORT, 2'b01 HI, 2'b10 LO; 2'b11 never driven
- `out_valid` output 1 chunk valid
- `out_ready` input 1 downstream consumes chunk
- `long_count` output 16 saturating count of constants that needed the HI/LO form

## Operation
- Handshakes:
  - Input transfers when `in_valid && in_ready`.
  - Output transfers when `out_valid && out_ready`.
- FSM states: IDLE, SHORT, HI, LO.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On input transfer, latch `in_data` into `hold`, then evaluate fit: fits iff `hold[15:11]` is all 0s or all 1s, i.e. the value lies in -2048..2047.
  - Fits: go to SHORT.
  - Does not fit: go to HI and increment `long_count` (sticks at 16'hFFFF).
- SHORT: `out_valid`=1, `out_kind`=00, `out_imm`=`hold[11:0]`. On output transfer, go to IDLE.
- HI: `out_valid`=1, `out_kind`=01, `out_imm`=`hold[15:4]`. On output transfer, go to LO.
- LO: `out_valid`=1, `out_kind`=10, `out_imm`={8'b0, `hold[3:0]`}. On output transfer, go to IDLE.
- Reconstruction contract:
  - SHORT: value = signext(`imm`).
  - HI/LO: value = (signext(HI) << 4) | LO[3:0].
- `in_ready`=0 in SHORT, HI and LO. The block holds one constant at a time, with no skid buffer.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_imm` and `out_kind` hold constant. `hold` is not written outside IDLE.
- `in_valid` asserted in a non-IDLE state is ignored. The upstream holds the value until `in_ready`.
- Values with LO payload 0 (e.g. 0x0800) still emit both chunks. No optimisation.

## Timing
- Reset values:
  - state=IDLE, `hold`=0, `long_count`=0.
  - `in_ready`=1, `out_valid`=0, `out_imm`=0, `out_kind`=00.
- Outputs are registered or decoded from state plus `hold` only. There is no combinational path from `in_*` to `out_*`, nor from `out_ready` to `in_ready`.
- Latency: input accepted at edge N gives `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput with `out_ready` held high:
  - SHORT: 1 constant per 2 cycles.
  - HI/LO: 1 constant per 3 cycles.
- Reset asserted mid-sequence (e.g. in HI) returns the block to IDLE immediately. The pending LO chunk is dropped and `long_count` clears.
- Deassertion of `rst` is expected synchronous to `clk`. The first accept can occur on the first edge after release.

## Test plan
- Reset; `in_data`=16'h07FF, then 16'hF800, `out_ready`=1 → two SHORT chunks with `out_imm`=12'h7FF and then 12'h800; `long_count`=0.
- `in_data`=16'h1234 → HI 12'h123, then LO 12'h004 on consecutive cycles; `long_count`=1.
- Boundaries: 16'h0800 → HI 12'h080, LO 12'h000. 16'hF7FF → HI 12'hF7F, LO 12'h00F. 16'h8000 → HI 12'h800, LO 12'h000.
- Backpressure: `out_ready`=0 for 5 cycles during HI with `in_valid` held on a new value. Required: chunk stable, `in_ready`=0, and the new value is accepted only after LO transfers.
- Reset pulse asserted while in HI → `out_valid`=0 in the same cycle, no LO emitted, `long_count`=0, `in_ready`=1.
- Exhaustive sweep of all 65536 inputs with a reconstruction model using the contract above: decoded value == input for every case. SHORT count must be 4096 and `long_count` must reach 61440.
